menu_settings_ctrl: RTL
=======================

MENU_SETTINGS_CTRL -- requirements
Module: menu_settings_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles before a button level is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 500000000: idle cycles before automatic menu exit (REQ-024).
REQ-003 Ports: clk in 1 system clock; rst_n in 1 async active-low reset.
REQ-004 Ports: btn_menu, btn_next, btn_inc, btn_dec in 1 each; raw asynchronous push-button levels, active-high.
REQ-005 Ports: menu_sel out 4; 0 = run mode, 1..7 = selected item (1 N, 2 S, 3 W, 4 E, 5 yellow duration, 6 red hold, 7 yellow count).
REQ-006 Ports: n_duration, s_duration, w_duration, e_duration, yellow_duration, red_holding, yellow_light_count out 8 each; current settings in binary.
REQ-007 Ports: cfg_update out 1; one-cycle pulse when the menu is exited.

Function
REQ-008 Each button passes through a 2-flop synchronizer and then a debouncer; the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-009 A press is a one-cycle pulse on a debounced 0->1 transition; releases generate nothing; a held button yields exactly one press.
REQ-010 States: RUN (menu_sel=0) and EDIT (menu_sel 1..7).
REQ-011 RUN + menu press -> EDIT, menu_sel=1 on the next cycle.
REQ-012 EDIT + menu press -> RUN, menu_sel=0, cfg_update=1 for exactly that one cycle.
REQ-013 EDIT + next press -> menu_sel+1; 7 wraps to 1.
REQ-014 EDIT + inc press -> selected setting +1, saturating at its max; dec press -> -1, saturating at its min; no wrap-around.
REQ-015 Bounds [min,max]: N/S/W/E 5..99; yellow_duration 1..9; red_holding 0..9; yellow_light_count 0..99.
REQ-016 In RUN, next/inc/dec presses are ignored and settings do not change.
REQ-017 Same-cycle priority: menu > next > inc/dec; inc and dec together -> no change; a lower-priority press in that cycle is discarded, not deferred.
REQ-018 Settings update one cycle after the press pulse and are registered outputs; all values stay within their bounds at all times.
REQ-019 cfg_update is registered and is never asserted in two consecutive cycles.

Reset
REQ-020 rst_n low asynchronously forces: menu_sel=0, state RUN, cfg_update=0, N/S/W/E=10, yellow_duration=3, red_holding=2, yellow_light_count=3, debounced levels=0, debounce and timeout counters=0.
REQ-021 Reset during EDIT discards edits without a cfg_update pulse; a button held through reset release produces no press until released and pressed again.
REQ-022 Reset deassertion is synchronized to clk inside the block; all state leaves reset on the same clk edge.

Configuration
REQ-023 Macro MENU_TIMEOUT_EN enables the inactivity timeout; without it, EDIT is left only by a menu press or reset, and the timeout counter is not built.
REQ-024 With MENU_TIMEOUT_EN: in EDIT, a counter clears on any press and counts otherwise; when it reaches TIMEOUT_CYCLES, the block takes the REQ-012 exit (menu_sel=0, one cycle of cfg_update); a press in the same cycle wins and clears the counter.

Structure
REQ-025 Shared package menu_pkg holds the menu item codes 0..7, the per-item MIN/MAX bounds and the reset default values; the text overlay and this block use the same item codes.
REQ-026 One sub-module, button_debounce (synchronizer + debouncer + rising-edge pulse, parameter DEBOUNCE_CYCLES), is instantiated four times.

Verification (bench DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-027 Reset, then btn_menu high for 10 cycles -> menu_sel 0->1 once, no cfg_update; a 3-cycle glitch on btn_menu -> no change.
REQ-028 EDIT on item 1: 7 next presses -> menu_sel 2,3,4,5,6,7,1.
REQ-029 Item 5 (yellow_duration=3): 8 inc presses -> 4..9 then held at 9; 12 dec presses -> held at 1.
REQ-030 Item 1: btn_inc and btn_dec pressed in the same cycle -> n_duration stays 10; btn_menu and btn_inc in the same cycle -> RUN, n_duration 10, cfg_update one cycle.
REQ-031 With MENU_TIMEOUT_EN: enter EDIT, no presses -> 100 cycles later menu_sel=0 with one cfg_update; without the macro, menu_sel stays 1 for 1000 cycles.
REQ-032 rst_n pulsed low mid-EDIT after n_duration was raised to 15 -> immediately menu_sel=0, n_duration=10, no cfg_update.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared menu item codes, per-item bounds and reset defaults for the settings
// controller and the text overlay.
package menu_pkg;

    typedef enum logic [3:0] {
        ITEM_RUN   = 4'd0,
        ITEM_N     = 4'd1,
        ITEM_S     = 4'd2,
        ITEM_W     = 4'd3,
        ITEM_E     = 4'd4,
        ITEM_YDUR  = 4'd5,
        ITEM_RHOLD = 4'd6,
        ITEM_YCNT  = 4'd7
    } menu_item_t;

    localparam logic [7:0] DUR_MIN   = 8'd5;
    localparam logic [7:0] DUR_MAX   = 8'd99;
    localparam logic [7:0] DUR_DEF   = 8'd10;
    localparam logic [7:0] YDUR_MIN  = 8'd1;
    localparam logic [7:0] YDUR_MAX  = 8'd9;
    localparam logic [7:0] YDUR_DEF  = 8'd3;
    localparam logic [7:0] RHOLD_MIN = 8'd0;
    localparam logic [7:0] RHOLD_MAX = 8'd9;
    localparam logic [7:0] RHOLD_DEF = 8'd2;
    localparam logic [7:0] YCNT_MIN  = 8'd0;
    localparam logic [7:0] YCNT_MAX  = 8'd99;
    localparam logic [7:0] YCNT_DEF  = 8'd3;

    function automatic logic [7:0] item_min(input logic [2:0] idx);
        case (idx)
            3'd5:    item_min = YDUR_MIN;
            3'd6:    item_min = RHOLD_MIN;
            3'd7:    item_min = YCNT_MIN;
            default: item_min = DUR_MIN;
        endcase
    endfunction

    function automatic logic [7:0] item_max(input logic [2:0] idx);
        case (idx)
            3'd5:    item_max = YDUR_MAX;
            3'd6:    item_max = RHOLD_MAX;
            3'd7:    item_max = YCNT_MAX;
            default: item_max = DUR_MAX;
        endcase
    endfunction

    function automatic logic [7:0] item_default(input logic [2:0] idx);
        case (idx)
            3'd5:    item_default = YDUR_DEF;
            3'd6:    item_default = RHOLD_DEF;
            3'd7:    item_default = YCNT_DEF;
            default: item_default = DUR_DEF;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stable-count debouncer and a
// one-cycle rising-edge press pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_q;
    logic          armed;
    logic [CW-1:0] cnt;

    // Synchronizer resets to 1 so a button held through reset never looks
    // like a fresh press; arming waits until the input has been seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '1;
            level   <= 1'b0;
            level_q <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            if (!sync[1])
                armed <= 1'b1;
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q & armed;

endmodule

// File: rtl/menu_settings_ctrl.sv
// Traffic-light settings menu: four debounced buttons edit seven bounded
// settings. Define MENU_TIMEOUT_EN to build the inactivity auto-exit.
module menu_settings_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_menu,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [3:0] menu_sel,
    output logic [7:0] n_duration,
    output logic [7:0] s_duration,
    output logic [7:0] w_duration,
    output logic [7:0] e_duration,
    output logic [7:0] yellow_duration,
    output logic [7:0] red_holding,
    output logic [7:0] yellow_light_count,
    output logic       cfg_update
);

    import menu_pkg::*;

    typedef enum logic {ST_RUN, ST_EDIT} state_t;

    logic [1:0] rst_sync;
    logic       rst_i_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_i_n = rst_sync[1];

    logic p_menu, p_next, p_inc, p_dec;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_menu (
        .clk(clk), .rst_n(rst_i_n), .btn(btn_menu), .press(p_menu));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .rst_n(rst_i_n), .btn(btn_next), .press(p_next));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .rst_n(rst_i_n), .btn(btn_inc), .press(p_inc));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .rst_n(rst_i_n), .btn(btn_dec), .press(p_dec));

    state_t     state;
    menu_item_t sel_q;
    logic       cfg_q;
    logic [7:0] settings [1:7];
    logic [2:0] idx;
    logic [7:0] cur;
    logic       tmo_hit;

    assign idx = sel_q[2:0];
    assign cur = settings[idx];

`ifdef MENU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          any_press;

    assign any_press = p_menu | p_next | p_inc | p_dec;
    assign tmo_hit   = (state == ST_EDIT) && !any_press &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n)
            tmo_cnt <= '0;
        else if (state != ST_EDIT || any_press || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state <= ST_RUN;
            sel_q <= ITEM_RUN;
            cfg_q <= 1'b0;
            for (int unsigned i = 1; i <= 7; i++)
                settings[i] <= item_default(3'(i));
        end else begin
            cfg_q <= 1'b0;
            if (p_menu || tmo_hit) begin
                if (state == ST_RUN) begin
                    state <= ST_EDIT;
                    sel_q <= ITEM_N;
                end else begin
                    state <= ST_RUN;
                    sel_q <= ITEM_RUN;
                    cfg_q <= 1'b1;
                end
            end else if (state == ST_EDIT) begin
                // Lower-priority presses in the same cycle are dropped.
                if (p_next)
                    sel_q <= (sel_q == ITEM_YCNT) ? ITEM_N : menu_item_t'(sel_q + 4'd1);
                else if (p_inc && !p_dec) begin
                    if (cur < item_max(idx))
                        settings[idx] <= cur + 8'd1;
                end else if (p_dec && !p_inc) begin
                    if (cur > item_min(idx))
                        settings[idx] <= cur - 8'd1;
                end
            end
        end
    end

    assign menu_sel           = sel_q;
    assign cfg_update         = cfg_q;
    assign n_duration         = settings[1];
    assign s_duration         = settings[2];
    assign w_duration         = settings[3];
    assign e_duration         = settings[4];
    assign yellow_duration    = settings[5];
    assign red_holding        = settings[6];
    assign yellow_light_count = settings[7];

endmodule
